// File: rtl/accum4_stream.sv
// accum4_stream: frames LEN unsigned 4-bit samples through the 4-bit
// ripple-carry adder (carry4bitrip). It presents the frame total and an
// overflow flag on a valid/ready output port.
// Optional feature macro: ACCUM4_SAT_EN. When it is defined, the accumulator
// saturates at 15 instead of wrapping modulo 16.

// carry4bitrip: 4-bit ripple-carry adder without a carry-out, so the result is
// the sum modulo 16.
module carry4bitrip (
    input  logic [3:0] n1,
    input  logic [3:0] n2,
    output logic [3:0] outy
);
    // c[i] is the carry into bit i. The carry out of bit 3 is not needed.
    logic [3:0] c;

    assign c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign outy[gi] = n1[gi] ^ n2[gi] ^ c[gi];
            if (gi < 3) begin : g_carry
                assign c[gi+1] = (n1[gi] & n2[gi]) | (c[gi] & (n1[gi] ^ n2[gi]));
            end
        end
    endgenerate
endmodule

module accum4_stream #(
    parameter int LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_ovf
);
    // Sample index that closes the frame.
    localparam logic [3:0] LAST = 4'(LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;

    logic [3:0] add_sum;
    logic       wrap;
    logic       accept;

    // The adder feeds back from the accumulator register.
    carry4bitrip u_adder (
        .n1   (acc_q),
        .n2   (in_data),
        .outy (add_sum)
    );

    // The adder has no carry-out, so overflow shows up as the sum dropping
    // below the old accumulator value.
    assign wrap   = (add_sum < acc_q);
    assign accept = in_valid && (state_q == ACC);

    // The handshake flags come straight from the state register, and the
    // result comes straight from the accumulator and overflow registers.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    // Next-state logic: accumulate in ACC, then hold the result until it is taken.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC: begin
                if (accept) begin
`ifdef ACCUM4_SAT_EN
                    // Once acc reaches 15, any non-zero sample wraps again,
                    // so acc stays pinned at 15 for the rest of the frame.
                    acc_d = wrap ? 4'hF : add_sum;
`else
                    acc_d = add_sum;
`endif
                    ovf_d = ovf_q | wrap;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = 4'd0;
                    cnt_d   = 4'd0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State registers. Reset clears everything at once and drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= 4'd0;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_accum4_stream.sv
// Directed testbench for accum4_stream. It uses one LEN=4 instance and one
// LEN=1 instance. Inputs are driven and outputs are checked on the falling edge.
`timescale 1ns/1ps
module tb_accum4_stream;
    logic       clk = 1'b0;
    logic       rst_n;

    // LEN=4 instance
    logic       in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [3:0] in_data, out_sum;

    // LEN=1 instance
    logic       v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_out_ovf;
    logic [3:0] v1_in_data, v1_out_sum;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    accum4_stream #(.LEN(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    accum4_stream #(.LEN(1)) u_len1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1_in_valid),
        .in_ready  (v1_in_ready),
        .in_data   (v1_in_data),
        .out_valid (v1_out_valid),
        .out_ready (v1_out_ready),
        .out_sum   (v1_out_sum),
        .out_ovf   (v1_out_ovf)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Present one sample for one cycle. Every caller does this while in_ready is high.
    task automatic feed(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 4'd0;
        out_ready    = 1'b1;
        v1_in_valid  = 1'b0;
        v1_in_data   = 4'd0;
        v1_out_ready = 1'b1;

        // Reset values
        #1;
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_sum", 8'(out_sum), 8'd0);
        check("rst_out_ovf", 8'(out_ovf), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1,2,3,4 back-to-back -> 10, no overflow, exactly one HOLD cycle
        feed(4'd1); feed(4'd2); feed(4'd3); feed(4'd4);
        check("t1_out_valid", 8'(out_valid), 8'd1);
        check("t1_in_ready", 8'(in_ready), 8'd0);
        check("t1_out_sum", 8'(out_sum), 8'd10);
        check("t1_out_ovf", 8'(out_ovf), 8'd0);
        @(negedge clk);
        check("t1_out_valid_drop", 8'(out_valid), 8'd0);
        check("t1_in_ready_back", 8'(in_ready), 8'd1);

        // 15,1,0,0 -> wraps to 0, or saturates at 15
        feed(4'd15); feed(4'd1); feed(4'd0); feed(4'd0);
        check("t2_out_valid", 8'(out_valid), 8'd1);
`ifdef ACCUM4_SAT_EN
        check("t2_out_sum", 8'(out_sum), 8'd15);
`else
        check("t2_out_sum", 8'(out_sum), 8'd0);
`endif
        check("t2_out_ovf", 8'(out_ovf), 8'd1);
        @(negedge clk);

        // 2,2,2,2 with back-pressure for 5 cycles and stray in_valid pulses
        out_ready = 1'b0;
        feed(4'd2); feed(4'd2); feed(4'd2); feed(4'd2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold%0d_valid", i), 8'(out_valid), 8'd1);
            check($sformatf("t3_hold%0d_sum", i), 8'(out_sum), 8'd8);
            check($sformatf("t3_hold%0d_in_ready", i), 8'(in_ready), 8'd0);
            in_valid = (i % 2 == 0);
            in_data  = 4'd9;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        check("t3_still_valid", 8'(out_valid), 8'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_out_valid_drop", 8'(out_valid), 8'd0);
        check("t3_in_ready_back", 8'(in_ready), 8'd1);
        check("t3_acc_cleared", 8'(out_sum), 8'd0);

        // 5,_,6,_,_,7,3 with input gaps -> 21 mod 16 = 5 (or saturated 15)
        feed(4'd5); idle(1); feed(4'd6); idle(2); feed(4'd7);
        check("t4_not_yet_valid", 8'(out_valid), 8'd0);
        feed(4'd3);
        check("t4_out_valid", 8'(out_valid), 8'd1);
`ifdef ACCUM4_SAT_EN
        check("t4_out_sum", 8'(out_sum), 8'd15);
`else
        check("t4_out_sum", 8'(out_sum), 8'd5);
`endif
        check("t4_out_ovf", 8'(out_ovf), 8'd1);
        @(negedge clk);

        // Reset mid-frame after 7,7, then 1,1,1,1 -> 4, no overflow
        feed(4'd7); feed(4'd7);
        check("t5_partial_sum", 8'(out_sum), 8'd14);
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", 8'(in_ready), 8'd1);
        check("t5_rst_out_valid", 8'(out_valid), 8'd0);
        check("t5_rst_out_sum", 8'(out_sum), 8'd0);
        check("t5_rst_out_ovf", 8'(out_ovf), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        feed(4'd1); feed(4'd1); feed(4'd1);
        check("t5_no_early_valid", 8'(out_valid), 8'd0);
        feed(4'd1);
        check("t5_out_valid", 8'(out_valid), 8'd1);
        check("t5_out_sum", 8'(out_sum), 8'd4);
        check("t5_out_ovf", 8'(out_ovf), 8'd0);
        @(negedge clk);

        // LEN=1: samples 9,9 with the producer holding valid -> two results
        v1_in_valid = 1'b1;
        v1_in_data  = 4'd9;
        @(negedge clk);
        check("t6_r1_valid", 8'(v1_out_valid), 8'd1);
        check("t6_r1_sum", 8'(v1_out_sum), 8'd9);
        check("t6_r1_ovf", 8'(v1_out_ovf), 8'd0);
        check("t6_r1_in_ready", 8'(v1_in_ready), 8'd0);
        @(negedge clk);
        check("t6_gap_valid", 8'(v1_out_valid), 8'd0);
        check("t6_gap_in_ready", 8'(v1_in_ready), 8'd1);
        @(negedge clk);
        v1_in_valid = 1'b0;
        check("t6_r2_valid", 8'(v1_out_valid), 8'd1);
        check("t6_r2_sum", 8'(v1_out_sum), 8'd9);
        check("t6_r2_ovf", 8'(v1_out_ovf), 8'd0);
        @(negedge clk);
        check("t6_end_valid", 8'(v1_out_valid), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/accum4_stream.md
# accum4_stream

- Sequential accumulator that consumes the 4-bit sum produced by the team's 4-bit ripple-carry adder (`carry4bitrip`, instantiated inside this block).
- Drives adder operand `n1` from its accumulator register and operand `n2` from an input stream, and registers the adder's `outy` every accepted sample.
- After `LEN` samples it presents the frame total, plus an overflow flag, on a valid/ready output port.
- It is the first clocked stage behind the combinational adder.

## Interface
- `LEN`, default 4: samples per frame; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` holds a sample.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_data` input 4: unsigned sample, fed to adder operand `n2`.
- `out_valid` output 1: frame result available.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output 4: frame total, modulo 16 (or saturated; see Configuration).
- `out_ovf` output 1: at least one addition in the frame exceeded 15.

## Operation
- State `ACC`:
  - `in_ready`=1, `out_valid`=0.
  - An accept is `in_valid & in_ready`.
  - On each accept: `acc` <= adder `outy` (`acc` + `in_data`, mod 16); `cnt` <= `cnt`+1; `ovf` <= `ovf` | wrap.
  - wrap = (`outy` < `acc`). The adder has no carry-out, so wrap is derived from this comparison.
- Transition `ACC` -> `HOLD`: on the accept where `cnt` == `LEN`-1.
- State `HOLD`:
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`=`acc`, `out_ovf`=`ovf`; both held stable.
  - On `out_ready`=1: clear `acc`, `cnt` and `ovf`, then return to `ACC`.
- `out_ready` is ignored in `ACC`.
- `in_valid` is ignored in `HOLD`; the producer must hold its data until `in_ready` is high.
- `out_sum` and `out_ovf` are registered. In `ACC` they show the running `acc`/`ovf`, but these values are only meaningful when `out_valid`=1.
- `in_valid` low in `ACC`: no state change; gaps of any length are allowed.
- `in_data`=0 never sets wrap.
- `LEN`=1: every accept moves the block to `HOLD`.

## Timing
- Reset values: `acc`=0, `cnt`=0, `ovf`=0, state=`ACC`, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0.
- Reset asserted mid-frame or in `HOLD`: all state clears immediately and any partial frame is discarded. After reset is released, the next accept is sample 0.
- Throughput: one sample per cycle in `ACC`.
- Latency: `out_valid` rises on the clock edge that accepts the last sample, so the result is visible in the following cycle.
- Handshake completes on the edge where `out_valid` & `out_ready`. `in_ready` rises on that same edge.
- Minimum one-cycle input bubble per frame (the `HOLD` cycle).
- The adder sits between the `acc` register and the `acc` D-input. The combinational path is the 4-bit ripple plus the wrap comparator.

## Configuration
- `ACCUM4_SAT_EN` defined:
  - When wrap occurs, `acc` <= 15 instead of `outy`.
  - Once `acc`=15, it stays 15 for the rest of the frame.
  - `ovf` behaves as without the macro.
- `ACCUM4_SAT_EN` undefined: modulo-16 wrap, `acc` <= `outy` always.

## Test plan
- `LEN`=4; samples 1,2,3,4 back-to-back, `out_ready`=1 -> `out_valid` for 1 cycle, `out_sum`=10, `out_ovf`=0. `in_ready` low for exactly 1 cycle.
- `LEN`=4; samples 15,1,0,0:
  - Without macro -> `out_sum`=0, `out_ovf`=1.
  - With `ACCUM4_SAT_EN` -> `out_sum`=15, `out_ovf`=1.
- `LEN`=4; samples 2,2,2,2 with `out_ready` low 5 cycles after `out_valid` -> `out_valid`=1, `out_sum`=8 stable for all 5 cycles, `in_ready`=0, and `in_valid` pulses are ignored. Then `out_ready`=1 -> return to `ACC`, `in_ready`=1.
- `LEN`=4; samples 5,_,6,_,_,7,3 with `in_valid` gaps -> `out_sum`=5 (21 mod 16), `out_ovf`=1, result one cycle after the sample 3 accept.
- Reset pulse after 2 of 4 samples (7,7), then samples 1,1,1,1 -> `out_sum`=4, `out_ovf`=0. All outputs read the reset values while `rst_n`=0, with no wait for a clock edge.
- `LEN`=1; samples 9,9 -> two results of `out_sum`=9 each, `out_ovf`=0, separated by the `HOLD` cycle.
